sig_period_meter: RTL

- Measures the period and high time of a slow external square wave, in cycles of the 125 MHz system clock.
- Typical inputs are a divided blink clock or an external 1 Hz reference.
- Sits on the receive side of a divided-clock output: synchronises the asynchronous input, detects edges and runs a measurement FSM.
- Publishes coherent period/high-time pairs with a one-cycle valid strobe, and flags a stalled input by timeout.

---
 rtl/sig_period_meter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sig_period_meter.sv
// Period and high-time meter for a slow asynchronous square wave.
// Counts in clk cycles between synchronised rising edges; sticky timeout on a stalled input.
module sig_period_meter #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 250000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period_cycles,
    output logic [CNT_WIDTH-1:0] high_cycles,
    output logic                 meas_valid,
    output logic                 timeout,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [2:0]           sync_q, sync_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;

    logic                 rise, fall, cnt_last;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // sync_q[0]/[1] form the 2-FF synchroniser, sync_q[2] is the edge-detect delay
    always_comb begin
        sync_d = {sync_q[1:0], sig_in};
    end

    assign rise     = sync_q[1] & ~sync_q[2];
    assign fall     = ~sync_q[1] & sync_q[2];
    assign cnt_inc  = cnt_q + CNT_ONE;
    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = ARM;
            end
            ARM: begin
                if (!en)       state_d = IDLE;
                else if (rise) state_d = MEASURE;
            end
            MEASURE: begin
                if (!en)                   state_d = IDLE;
                else if (!rise && cnt_last) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
    end

    // A rise on the last counted cycle still yields a measurement
    always_comb begin
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (en) cnt_d = '0;
            end
            ARM: begin
                if (en) begin
                    if (rise) begin
                        cnt_d = '0;
                    end else if (cnt_last) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            MEASURE: begin
                if (en) begin
                    if (fall) shadow_d = cnt_inc;
                    if (rise) begin
                        period_d  = cnt_inc;
                        high_d    = shadow_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = '0;
                    end else if (cnt_last) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_comb begin
        busy          = (state_q != IDLE);
        period_cycles = period_q;
        high_cycles   = high_q;
        meas_valid    = valid_q;
        timeout       = timeout_q;
    end

endmodule
